// File: rtl/key_event_counter.sv
// key_event_counter: debounced active-low keys driving a 4-digit hex/BCD up/down counter with auto-run.
module key_event_counter #(
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int TICK_CYCLES = 24000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  key,
  input  logic [9:0]  sw,
  output logic [15:0] digits,
  output logic        carry,
  output logic        running,
  output logic [3:0]  key_pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int PW = $clog2(TICK_CYCLES);
  logic [3:0] sync1, sync2, deb, deb_d;
  logic [CW-1:0] stab [4];
  logic [PW-1:0] pre;
  logic tick, step, wrap, c;
  logic [3:0] d, lo0, lo1;
  logic [16:0] hex_res;
  logic [15:0] bcd_res, stepped;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
      deb <= '1;
      deb_d <= '1;
      key_pulse <= '0;
      for (int i = 0; i < 4; i++) stab[i] <= '0;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
      deb_d <= deb;
      key_pulse <= deb_d & ~deb;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == deb[i]) stab[i] <= '0;
        else if (stab[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          deb[i] <= sync2[i];
          stab[i] <= '0;
        end else stab[i] <= stab[i] + 1'b1;
      end
    end
  end
  // Tick is registered so the first auto step lands TICK_CYCLES+1 edges after running rises.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre <= '0;
      tick <= 1'b0;
    end else begin
      pre <= key_pulse[1] ? '0 : !running ? pre : (pre == PW'(TICK_CYCLES - 1)) ? '0 : pre + 1'b1;
      tick <= running && pre == PW'(TICK_CYCLES - 1) && !key_pulse[1];
    end
  end
  always_comb begin
    step = key_pulse[0] | tick;
    hex_res = sw[1] ? {1'b0, digits} - 17'd1 : {1'b0, digits} + 17'd1;
    bcd_res = digits;
    c = 1'b1;
    d = '0;
    for (int j = 0; j < 4; j++) begin
      d = digits[4*j +: 4];
      bcd_res[4*j +: 4] = !c ? d : !sw[1] ? (d >= 4'd9 ? 4'd0 : d + 4'd1) : (d == 4'd0 || d > 4'd9) ? 4'd9 : d - 4'd1;
      c = c && (sw[1] ? d == 4'd0 : d >= 4'd9);
    end
    {wrap, stepped} = sw[0] ? {c, bcd_res} : hex_res;
    lo1 = (sw[0] && sw[9:6] > 4'd9) ? 4'd9 : sw[9:6];
    lo0 = (sw[0] && sw[5:2] > 4'd9) ? 4'd9 : sw[5:2];
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      digits <= '0;
      carry <= 1'b0;
      running <= 1'b0;
    end else begin
      running <= running ^ key_pulse[3];
      carry <= !key_pulse[1] && !key_pulse[2] && step && wrap;
      digits <= key_pulse[1] ? 16'h0000 : key_pulse[2] ? {8'h00, lo1, lo0} : step ? stepped : digits;
    end
  end
endmodule

// File: tb/tb_key_event_counter.sv
// tb_key_event_counter: directed and random stimulus against a behavioural model of the key counter.
module tb_key_event_counter;
  localparam int D = 4;
  localparam int T = 8;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [3:0] key = 4'hF;
  logic [9:0] sw = '0;
  logic [15:0] digits;
  logic carry, running;
  logic [3:0] key_pulse;
  key_event_counter #(.DEBOUNCE_CYCLES(D), .TICK_CYCLES(T)) dut (
    .clock(clock), .reset(reset), .key(key), .sw(sw),
    .digits(digits), .carry(carry), .running(running), .key_pulse(key_pulse)
  );
  always #5 clock = ~clock;
  int checks = 0, errors = 0, cycle = 0, p0_at = 0;
  int pcount [4];
  bit carry_seen;
  logic [15:0] carry_digits;
  logic [3:0] m_lag, m_syn, m_deb, m_deb_prev, m_pulse;
  int m_streak [4];
  int m_v, m_pre;
  bit m_carry, m_run, m_tick;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic m_reset();
    m_lag = '1; m_syn = '1; m_deb = '1; m_deb_prev = '1; m_pulse = '0;
    for (int i = 0; i < 4; i++) m_streak[i] = 0;
    m_v = 0; m_pre = 0; m_carry = 0; m_run = 0; m_tick = 0;
  endtask
  function automatic int clampv(input logic [3:0] n, input bit bcd);
    return (bcd && n > 9) ? 9 : int'(n);
  endfunction
  function automatic void bcd_step(input int v, input bit down, output int nv, output bit c);
    int dg;
    c = 1; nv = 0;
    for (int j = 0; j < 4; j++) begin
      dg = (v >> (4 * j)) & 15;
      if (c) begin
        if (!down) begin
          if (dg >= 9) dg = 0; else begin dg = dg + 1; c = 0; end
        end else if (dg == 0) dg = 9;
        else begin dg = (dg > 9) ? 9 : dg - 1; c = 0; end
      end
      nv = nv | (dg << (4 * j));
    end
  endfunction
  task automatic model_edge(input logic [3:0] k, input logic [9:0] s);
    logic [3:0] ndeb;
    int nv, npre;
    bit nc, ntick;
    nv = m_v; nc = 0;
    if (m_pulse[1]) nv = 0;
    else if (m_pulse[2]) nv = clampv(s[9:6], s[0]) * 16 + clampv(s[5:2], s[0]);
    else if (m_pulse[0] || m_tick) begin
      if (s[0]) bcd_step(m_v, s[1], nv, nc);
      else begin
        nv = s[1] ? (m_v + 65535) % 65536 : (m_v + 1) % 65536;
        nc = s[1] ? (m_v == 0) : (m_v == 65535);
      end
    end
    ntick = m_run && m_pre == T - 1 && !m_pulse[1];
    npre = m_pulse[1] ? 0 : m_run ? (m_pre + 1) % T : m_pre;
    m_run = m_run ^ m_pulse[3];
    // A key level is accepted after D consecutive cycles of disagreement.
    ndeb = m_deb;
    for (int i = 0; i < 4; i++) begin
      if (m_syn[i] == m_deb[i]) m_streak[i] = 0;
      else if (m_streak[i] + 1 == D) begin ndeb[i] = m_syn[i]; m_streak[i] = 0; end
      else m_streak[i]++;
    end
    m_pulse = m_deb_prev & ~m_deb;
    m_deb_prev = m_deb;
    m_deb = ndeb;
    m_syn = m_lag;
    m_lag = k;
    m_v = nv; m_carry = nc; m_tick = ntick; m_pre = npre;
  endtask
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      model_edge(key, sw);
      #1;
      cycle++;
      chk("digits", 32'(digits), 32'(m_v));
      chk("carry", 32'(carry), 32'(m_carry));
      chk("running", 32'(running), 32'(m_run));
      chk("key_pulse", 32'(key_pulse), 32'(m_pulse));
      if (key_pulse[0] && pcount[0] == 0) p0_at = cycle;
      for (int i = 0; i < 4; i++) pcount[i] += int'(key_pulse[i]);
      if (carry) begin carry_seen = 1; carry_digits = digits; end
    end
  endtask
  task automatic press(input int idx);
    key[idx] = 1'b0;
    cyc(10);
    key[idx] = 1'b1;
    cyc(10);
  endtask
  task automatic clear_counts();
    for (int i = 0; i < 4; i++) pcount[i] = 0;
    carry_seen = 0;
    carry_digits = '0;
  endtask
  initial begin
    int v, start;
    m_reset();
    clear_counts();
    key = 4'hE;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_digits", 32'(digits), 0);
    chk("rst_carry", 32'(carry), 0);
    chk("rst_running", 32'(running), 0);
    chk("rst_pulse", 32'(key_pulse), 0);
    reset = 1'b0;
    cyc(6);
    chk("clean_no_pulse_yet", 32'(key_pulse), 0);
    cyc(1);
    chk("clean_pulse_edge7", 32'(key_pulse), 32'h1);
    cyc(1);
    chk("clean_digits_edge8", 32'(digits), 32'h0001);
    chk("clean_carry", 32'(carry), 0);
    cyc(20);
    chk("held_one_pulse", 32'(pcount[0]), 1);
    chk("held_digits", 32'(digits), 32'h0001);
    key = 4'hF;
    cyc(10);
    press(1);
    chk("clear", 32'(digits), 0);
    clear_counts();
    key[0] = 1'b0; cyc(2);
    key[0] = 1'b1; cyc(1);
    key[0] = 1'b0; start = cycle; cyc(12);
    key[0] = 1'b1; cyc(10);
    chk("bounce_pulses", 32'(pcount[0]), 1);
    chk("bounce_latency", 32'(p0_at - start), 7);
    chk("bounce_digits", 32'(digits), 32'h0001);
    sw = 10'b1111_0011_0_1;
    press(2);
    chk("bcd_load_clamp", 32'(digits), 32'h0093);
    repeat (7) press(0);
    chk("bcd_up_ripple", 32'(digits), 32'h0100);
    sw = 10'h002;
    press(1);
    clear_counts();
    press(0);
    chk("hex_down_wrap", 32'(digits), 32'hFFFF);
    chk("hex_wrap_carry", 32'(carry_seen), 1);
    chk("hex_carry_with_digits", 32'(carry_digits), 32'hFFFF);
    sw = 10'h003;
    press(1);
    clear_counts();
    press(0);
    chk("bcd_down_wrap", 32'(digits), 32'h9999);
    chk("bcd_wrap_carry", 32'(carry_seen), 1);
    chk("bcd_carry_with_digits", 32'(carry_digits), 32'h9999);
    sw = 10'h000;
    press(1);
    key[3] = 1'b0;
    cyc(8);
    chk("run_on", 32'(running), 1);
    start = cycle;
    for (int n = 0; n < 20 && digits == 16'h0000; n++) cyc(1);
    chk("first_tick_latency", 32'(cycle - start), 9);
    v = m_v;
    cyc(7);
    chk("tick_hold", 32'(digits), 32'(v));
    cyc(1);
    chk("tick_period", 32'(digits), 32'(v + 1));
    key[3] = 1'b1;
    cyc(10);
    for (int n = 0; n < 20 && m_pre != 1; n++) cyc(1);
    key[1] = 1'b0;
    cyc(7);
    chk("coincide_pulse", 32'(key_pulse[1]), 1);
    chk("coincide_tick", 32'(dut.tick), 1);
    cyc(1);
    chk("coincide_digits", 32'(digits), 0);
    chk("coincide_prescaler", 32'(dut.pre), 0);
    key[1] = 1'b1;
    cyc(10);
    press(3);
    chk("run_off", 32'(running), 0);
    v = m_v;
    cyc(30);
    chk("paused", 32'(digits), 32'(v));
    sw = 10'h3FC;
    press(2);
    chk("hex_load", 32'(digits), 32'h00FF);
    press(3);
    key[0] = 1'b0;
    cyc(4);
    #2 reset = 1'b1;
    m_reset();
    #1;
    chk("async_rst_digits", 32'(digits), 0);
    chk("async_rst_running", 32'(running), 0);
    chk("async_rst_pulse", 32'(key_pulse), 0);
    chk("async_rst_carry", 32'(carry), 0);
    key[0] = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    clear_counts();
    cyc(20);
    chk("post_rst_no_pulse", 32'(pcount[0]), 0);
    press(0);
    chk("post_rst_fresh_pulse", 32'(pcount[0]), 1);
    chk("post_rst_digits", 32'(digits), 32'h0001);
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++) if ($urandom_range(11) == 0) key[i] = ~key[i];
      if ($urandom_range(49) == 0) sw = 10'($urandom);
      cyc(1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
